// File: rtl/handshake_dispatch_pkg.sv
// handshake_pkg
// Shared types and helpers for the handshake dispatcher.
//   state_e      dispatcher FSM state encoding
//   COUNT_W_DEF  default transfer-counter width
//   MAX_LANES    largest supported lane count
//   is_onehot()  true when exactly one bit of a lane vector is set
package handshake_pkg;

   localparam int COUNT_W_DEF = 16;
   localparam int MAX_LANES   = 32;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FWD     = 3'd1,
      ST_HOLD    = 3'd2,
      ST_DROP    = 3'd3,
      ST_ERR_ACK = 3'd4,
      ST_ERR_REL = 3'd5
   } state_e;

   localparam logic [MAX_LANES-1:0] LANE_ONE = MAX_LANES'(1);

   // Clearing the lowest set bit leaves zero only for a single-bit vector.
   function automatic logic is_onehot(input logic [MAX_LANES-1:0] v);
      return (v != '0) && ((v & (v - LANE_ONE)) == '0);
   endfunction

endpackage

// File: rtl/handshake_dispatch_if.sv
// handshake_dispatch_if
// Bundles the upstream handshake, the per-lane target handshake and the
// status outputs of the dispatcher.
//   req_in      merged request from the arbiter root
//   ack_in      acknowledge back to the arbiter root
//   sel         one-hot lane select, valid while req_in is high
//   req_out     per-lane request to the targets
//   ack_out     per-lane acknowledge from the targets
//   busy        dispatcher not idle
//   err         sticky malformed-select flag
//   xfer_count  completed lane transfers
// Modports:
//   slave   the dispatcher itself
//   master  the arbiter root plus the targets (or a testbench standing in)
interface handshake_dispatch_if
   import handshake_pkg::*;
#(
   parameter int output_size = 8,
   parameter int COUNT_W     = COUNT_W_DEF
);

   logic                   req_in;
   logic                   ack_in;
   logic [output_size-1:0] sel;
   logic [output_size-1:0] req_out;
   logic [output_size-1:0] ack_out;
   logic                   busy;
   logic                   err;
   logic [COUNT_W-1:0]     xfer_count;

   modport slave (
      input  req_in,
      input  sel,
      input  ack_out,
      output ack_in,
      output req_out,
      output busy,
      output err,
      output xfer_count
   );

   modport master (
      output req_in,
      output sel,
      output ack_out,
      input  ack_in,
      input  req_out,
      input  busy,
      input  err,
      input  xfer_count
   );

endinterface

// File: rtl/handshake_dispatch_sync_2ff.sv
// sync_2ff
// Single-bit two-flop synchronizer for inputs arriving from another clock
// domain. Both flops clear on reset so a stale request cannot leak through.
//   clk   destination clock
//   rst   asynchronous active-high reset
//   d_i   asynchronous input
//   q_o   synchronized output, two edges behind d_i
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/handshake_dispatch.sv
// handshake_dispatch
// Receiving end of the cascade arbiter's output channel. Takes the merged
// four-phase request plus a one-hot select, forwards the request to the
// selected target lane, relays that lane's acknowledge back upstream and
// completes the four-phase cycle on both sides. Counts completed lane
// transfers and flags malformed selects.
//
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous active-high reset; abandons any transfer in flight
//   bus   handshake_dispatch_if.slave (req_in, sel, ack_out in;
//         ack_in, req_out, busy, err, xfer_count out)
//
// Build option HANDSHAKE_DISPATCH_SYNC_EN: when defined, req_in and every
// ack_out bit pass through two-flop synchronizers before the FSM sees them,
// adding two edges to every input-to-output latency. sel is not
// synchronized; it is captured only once the synchronized request is seen.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for req_in; captures sel into lane on acceptance
// ST_FWD     | request driven on lane, waiting for that lane's ack
// ST_HOLD    | lane acked, ack_in high, waiting for req_in to drop
// ST_DROP    | lane request released, waiting for lane ack to drop
// ST_ERR_ACK | malformed sel; ack_in high with no lane, waiting req_in low
// ST_ERR_REL | ack_in released after an error handshake, back to idle
//
// All outputs come straight from flops, computed from the next state.
module handshake_dispatch
   import handshake_pkg::*;
#(
   parameter int output_size = 8,
   parameter int COUNT_W     = COUNT_W_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   handshake_dispatch_if.slave  bus
);

   logic                   req_s;
   logic [output_size-1:0] ack_s;

`ifdef HANDSHAKE_DISPATCH_SYNC_EN
   sync_2ff u_sync_req (
      .clk (clk),
      .rst (rst),
      .d_i (bus.req_in),
      .q_o (req_s)
   );

   for (genvar g = 0; g < output_size; g++) begin : g_ack_sync
      sync_2ff u_sync_ack (
         .clk (clk),
         .rst (rst),
         .d_i (bus.ack_out[g]),
         .q_o (ack_s[g])
      );
   end
`else
   assign req_s = bus.req_in;
   assign ack_s = bus.ack_out;
`endif

   state_e                 state_q, state_d;
   logic [output_size-1:0] lane_q, lane_d;
   logic [output_size-1:0] req_out_q, req_out_d;
   logic                   ack_in_q, ack_in_d;
   logic                   busy_q, busy_d;
   logic                   err_q, err_d;
   logic [COUNT_W-1:0]     xfer_count_q, xfer_count_d;

   logic [MAX_LANES-1:0]   sel_ext;
   logic                   sel_ok;
   logic                   lane_ack;

   always_comb begin
      sel_ext                  = '0;
      sel_ext[output_size-1:0] = bus.sel;
   end

   assign sel_ok = is_onehot(sel_ext);

   // lane is one-hot, so masking picks out the selected lane's ack only;
   // activity on every other lane is ignored.
   assign lane_ack = |(ack_s & lane_q);

   always_comb begin
      state_d      = state_q;
      lane_d       = lane_q;
      err_d        = err_q;
      xfer_count_d = xfer_count_q;

      unique case (state_q)
         ST_IDLE: begin
            if (req_s) begin
               if (sel_ok) begin
                  lane_d  = bus.sel;
                  state_d = ST_FWD;
               end else begin
                  err_d   = 1'b1;
                  state_d = ST_ERR_ACK;
               end
            end
         end
         ST_FWD: begin
            if (lane_ack) begin
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (!req_s) begin
               state_d = ST_DROP;
            end
         end
         ST_DROP: begin
            if (!lane_ack) begin
               state_d      = ST_IDLE;
               xfer_count_d = xfer_count_q + COUNT_W'(1);
            end
         end
         ST_ERR_ACK: begin
            if (!req_s) begin
               state_d = ST_ERR_REL;
            end
         end
         ST_ERR_REL: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Deriving the registered outputs from the next state gives exactly one
   // edge between an input change and the matching output change.
   always_comb begin
      req_out_d = '0;
      ack_in_d  = 1'b0;
      busy_d    = (state_d != ST_IDLE);

      if ((state_d == ST_FWD) || (state_d == ST_HOLD)) begin
         req_out_d = lane_d;
      end
      if ((state_d == ST_HOLD) || (state_d == ST_DROP) ||
          (state_d == ST_ERR_ACK)) begin
         ack_in_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         lane_q       <= '0;
         req_out_q    <= '0;
         ack_in_q     <= 1'b0;
         busy_q       <= 1'b0;
         err_q        <= 1'b0;
         xfer_count_q <= '0;
      end else begin
         state_q      <= state_d;
         lane_q       <= lane_d;
         req_out_q    <= req_out_d;
         ack_in_q     <= ack_in_d;
         busy_q       <= busy_d;
         err_q        <= err_d;
         xfer_count_q <= xfer_count_d;
      end
   end

   assign bus.req_out    = req_out_q;
   assign bus.ack_in     = ack_in_q;
   assign bus.busy       = busy_q;
   assign bus.err        = err_q;
   assign bus.xfer_count = xfer_count_q;

endmodule

// File: tb/tb_handshake_dispatch.sv
// Self-checking bench for handshake_dispatch (default build, raw inputs).
// Expected values come from the handshake rules: each input change shows on
// the related output one edge later, the chosen lane is fixed at acceptance,
// and a completed lane transfer adds one to a modulo-2^16 counter.
module tb_handshake_dispatch;

   localparam int N  = 8;
   localparam int CW = 16;

   logic clk = 1'b0;
   logic rst;

   int total  = 0;
   int passed = 0;

   logic [CW-1:0] exp_count;
   logic          exp_err;

   always #5 clk = ~clk;

   handshake_dispatch_if #(.output_size(N), .COUNT_W(CW)) bus ();

   handshake_dispatch #(.output_size(N), .COUNT_W(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_outs(input string tag, input logic [N-1:0] req_exp,
                             input logic ack_exp, input logic busy_exp);
      check({tag, ".req_out"}, 32'(bus.req_out), 32'(req_exp));
      check({tag, ".ack_in"},  32'(bus.ack_in),  32'(ack_exp));
      check({tag, ".busy"},    32'(bus.busy),    32'(busy_exp));
      check({tag, ".onehot"},  32'($countones(bus.req_out) <= 1), 32'd1);
   endtask

   task automatic check_status(input string tag);
      check({tag, ".count"}, 32'(bus.xfer_count), 32'(exp_count));
      check({tag, ".err"},   32'(bus.err),        32'(exp_err));
   endtask

   task automatic do_reset();
      bus.req_in  = 1'b0;
      bus.sel     = '0;
      bus.ack_out = '0;
      rst         = 1'b1;
      exp_count   = '0;
      exp_err     = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // One full lane transfer. With rnd set, target response times vary,
   // sel wanders after acceptance and non-selected lanes carry random acks.
   task automatic xfer(input int lane, input bit rnd);
      logic [N-1:0] s;
      int           d;
      s           = N'(1) << lane;
      bus.sel     = s;
      bus.req_in  = 1'b1;
      bus.ack_out = rnd ? (N'($urandom) & ~s) : '0;
      tick();
      check_outs("x_fwd", s, 1'b0, 1'b1);
      d = rnd ? int'($urandom_range(3)) : 0;
      repeat (d) begin
         bus.sel     = N'($urandom);
         bus.ack_out = N'($urandom) & ~s;
         tick();
         check_outs("x_wait", s, 1'b0, 1'b1);
      end
      bus.ack_out = (rnd ? (N'($urandom) & ~s) : '0) | s;
      tick();
      check_outs("x_hold", s, 1'b1, 1'b1);
      d = rnd ? int'($urandom_range(2)) : 0;
      repeat (d) begin
         bus.sel     = N'($urandom);
         bus.ack_out = N'($urandom) | s;
         tick();
         check_outs("x_hold2", s, 1'b1, 1'b1);
      end
      bus.req_in = 1'b0;
      tick();
      check_outs("x_drop", '0, 1'b1, 1'b1);
      d = rnd ? int'($urandom_range(2)) : 0;
      repeat (d) begin
         bus.ack_out = N'($urandom) | s;
         tick();
         check_outs("x_drop2", '0, 1'b1, 1'b1);
      end
      bus.ack_out = rnd ? (N'($urandom) & ~s) : '0;
      tick();
      exp_count = exp_count + CW'(1);
      check_outs("x_idle", '0, 1'b0, 1'b0);
      check_status("x_idle");
   endtask

   initial begin
      bus.req_in  = 1'b0;
      bus.sel     = '0;
      bus.ack_out = '0;
      rst         = 1'b1;
      exp_count   = '0;
      exp_err     = 1'b0;
      #1;
      check_outs("reset", '0, 1'b0, 1'b0);
      check_status("reset");
      tick();
      tick();
      rst = 1'b0;

      // basic transfer on lane 2
      bus.sel    = 8'h04;
      bus.req_in = 1'b1;
      tick();
      check_outs("t1_fwd", 8'h04, 1'b0, 1'b1);
      bus.ack_out = 8'h04;
      tick();
      check_outs("t1_hold", 8'h04, 1'b1, 1'b1);
      bus.req_in = 1'b0;
      tick();
      check_outs("t1_drop", 8'h00, 1'b1, 1'b1);
      bus.ack_out = 8'h00;
      tick();
      exp_count = 1;
      check_outs("t1_idle", 8'h00, 1'b0, 1'b0);
      check_status("t1_idle");

      // malformed select: two bits set
      bus.sel    = 8'h06;
      bus.req_in = 1'b1;
      tick();
      exp_err = 1'b1;
      check_outs("t2_errack", 8'h00, 1'b1, 1'b1);
      check_status("t2_errack");
      bus.req_in = 1'b0;
      tick();
      check_outs("t2_errrel", 8'h00, 1'b0, 1'b1);
      tick();
      check_outs("t2_idle", 8'h00, 1'b0, 1'b0);
      check_status("t2_idle");

      // malformed select: zero bits set
      bus.sel    = 8'h00;
      bus.req_in = 1'b1;
      tick();
      check_outs("t2z_errack", 8'h00, 1'b1, 1'b1);
      bus.req_in = 1'b0;
      tick();
      tick();
      check_outs("t2z_idle", 8'h00, 1'b0, 1'b0);
      check_status("t2z_idle");

      // lane 0: foreign ack on lane 3, sel change during HOLD
      bus.sel    = 8'h01;
      bus.req_in = 1'b1;
      tick();
      check_outs("t3_fwd", 8'h01, 1'b0, 1'b1);
      bus.ack_out = 8'h08;
      tick();
      check_outs("t3_foreign", 8'h01, 1'b0, 1'b1);
      bus.ack_out = 8'h01;
      tick();
      check_outs("t3_hold", 8'h01, 1'b1, 1'b1);
      bus.sel     = 8'h80;
      bus.ack_out = 8'h09;
      tick();
      check_outs("t3_selchg", 8'h01, 1'b1, 1'b1);
      bus.req_in = 1'b0;
      tick();
      check_outs("t3_drop", 8'h00, 1'b1, 1'b1);
      bus.ack_out = 8'h08;
      tick();
      exp_count = exp_count + CW'(1);
      check_outs("t3_idle", 8'h00, 1'b0, 1'b0);
      check_status("t3_idle");
      bus.ack_out = 8'h00;

      // 100 random back-to-back transfers from a clean reset
      do_reset();
      for (int t = 0; t < 100; t++) begin
         xfer(int'($urandom_range(N - 1)), 1'b1);
      end
      check("rnd_total", 32'(bus.xfer_count), 32'd100);

      // counter wrap
      force dut.xfer_count_q = 16'hFFFF;
      #1;
      release dut.xfer_count_q;
      exp_count = 16'hFFFF;
      xfer(6, 1'b0);
      check("wrap", 32'(bus.xfer_count), 32'd0);

      // asynchronous reset while in HOLD
      bus.sel    = 8'h10;
      bus.req_in = 1'b1;
      tick();
      bus.ack_out = 8'h10;
      tick();
      check_outs("t6_hold", 8'h10, 1'b1, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      exp_count = '0;
      exp_err   = 1'b0;
      check_outs("t6_rst", 8'h00, 1'b0, 1'b0);
      check_status("t6_rst");
      bus.req_in  = 1'b0;
      bus.ack_out = '0;
      tick();
      rst = 1'b0;
      xfer(5, 1'b0);
      check("t6_after", 32'(bus.xfer_count), 32'd1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
